// File: rtl/nim_game_ctrl.sv
// Turn scheduler and screen sequencer for the pile game.
// Owns the pile status register, validates moves, alternates players and tracks round wins.
module nim_game_ctrl #(
  parameter int         PILES      = 10,
  parameter logic [3:0] INIT_VAL   = 4'h1,
  parameter int         MAX_TARGET = 7,
  parameter int         WIN_W      = 3,
  parameter int         ROUND_HOLD = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_enter,
  input  logic               key_help,
  input  logic               key_back,
  input  logic               key_up,
  input  logic               key_space,
  input  logic [3:0]         pile_sel,
  input  logic [3:0]         new_val,
  output logic [4*PILES-1:0] status,
  output logic [1:0]         screen,
  output logic               player,
  output logic [WIN_W-1:0]   win0,
  output logic [WIN_W-1:0]   win1,
  output logic [WIN_W-1:0]   target,
  output logic               round_over,
  output logic               match_over,
  output logic               last_winner,
  output logic               move_ok,
  output logic               move_err
);

  localparam int HOLD_W = (ROUND_HOLD > 1) ? $clog2(ROUND_HOLD) : 1;
  localparam logic [4*PILES-1:0] INIT_STATUS = {PILES{INIT_VAL}};

  typedef enum logic [2:0] {
    S_TITLE, S_HELP, S_SETUP, S_PLAY, S_ROUND_END, S_MATCH_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [4*PILES-1:0] status_q, status_d;
  logic               player_q, player_d;
  logic [WIN_W-1:0]   win0_q, win0_d, win1_q, win1_d, target_q, target_d;
  logic               last_winner_q, last_winner_d;
  logic               move_ok_q, move_ok_d, move_err_q, move_err_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [3:0]         cur_val;
  logic [4*PILES-1:0] written_status;
  logic               move_valid, all_zero, match_won, hold_done;
  logic [WIN_W-1:0]   win_inc;

  // Move evaluation: value of the selected pile and the status as it would look after the write.
  always_comb begin
    cur_val        = '0;
    written_status = status_q;
    for (int i = 0; i < PILES; i++) begin
      if (32'(pile_sel) == i) begin
        cur_val                  = status_q[4*i +: 4];
        written_status[4*i +: 4] = new_val;
      end
    end
    move_valid = (32'(pile_sel) < PILES) && (new_val < cur_val);
    all_zero   = (written_status == '0);
    win_inc    = (player_q ? win1_q : win0_q) + 1'b1;
    match_won  = (win_inc == target_q);
    hold_done  = (hold_q == HOLD_W'(ROUND_HOLD - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_TITLE;
      status_q      <= INIT_STATUS;
      player_q      <= 1'b0;
      win0_q        <= '0;
      win1_q        <= '0;
      target_q      <= WIN_W'(1);
      last_winner_q <= 1'b0;
      move_ok_q     <= 1'b0;
      move_err_q    <= 1'b0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      player_q      <= player_d;
      win0_q        <= win0_d;
      win1_q        <= win1_d;
      target_q      <= target_d;
      last_winner_q <= last_winner_d;
      move_ok_q     <= move_ok_d;
      move_err_q    <= move_err_d;
      hold_q        <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TITLE: begin
        if (key_back)       state_d = S_TITLE;
        else if (key_enter) state_d = S_SETUP;
        else if (key_help)  state_d = S_HELP;
      end
      S_HELP: begin
        if (key_back)       state_d = S_TITLE;
        else if (key_enter) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (key_back)       state_d = S_TITLE;
        else if (key_enter) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (key_back)
          state_d = S_TITLE;
        else if (key_space && move_valid && all_zero)
          state_d = match_won ? S_MATCH_OVER : S_ROUND_END;
      end
      S_ROUND_END: begin
        if (key_back)       state_d = S_TITLE;
        else if (hold_done) state_d = S_PLAY;
      end
      S_MATCH_OVER: begin
        if (key_back || key_enter) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase
  end

  always_comb begin
    status_d      = status_q;
    player_d      = player_q;
    win0_d        = win0_q;
    win1_d        = win1_q;
    target_d      = target_q;
    last_winner_d = last_winner_q;
    move_ok_d     = 1'b0;
    move_err_d    = 1'b0;
    hold_d        = hold_q;
    case (state_q)
      S_SETUP: begin
        if (!key_back && key_enter) begin
          status_d = INIT_STATUS;
          win0_d   = '0;
          win1_d   = '0;
          player_d = 1'b0;
        end else if (!key_back && key_up) begin
          target_d = (target_q == WIN_W'(MAX_TARGET)) ? WIN_W'(1) : target_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (!key_back && key_space) begin
          if (move_valid) begin
            status_d  = written_status;
            move_ok_d = 1'b1;
            player_d  = ~player_q;
            if (all_zero) begin
              last_winner_d = player_q;
              hold_d        = '0;
              if (player_q) win1_d = win_inc;
              else          win0_d = win_inc;
            end
          end else begin
            move_err_d = 1'b1;
          end
        end
      end
      S_ROUND_END: begin
        if (!key_back) begin
          if (hold_done) begin
            status_d = INIT_STATUS;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Entering TITLE from any other screen starts the next match from zero wins.
    if (state_d == S_TITLE && state_q != S_TITLE) begin
      win0_d = '0;
      win1_d = '0;
    end
  end

  always_comb begin
    case (state_q)
      S_TITLE: screen = 2'b00;
      S_HELP:  screen = 2'b01;
      S_SETUP: screen = 2'b10;
      default: screen = 2'b11;
    endcase
  end

  assign status      = status_q;
  assign player      = player_q;
  assign win0        = win0_q;
  assign win1        = win1_q;
  assign target      = target_q;
  assign round_over  = (state_q == S_ROUND_END);
  assign match_over  = (state_q == S_MATCH_OVER);
  assign last_winner = last_winner_q;
  assign move_ok     = move_ok_q;
  assign move_err    = move_err_q;

endmodule

// File: tb/tb_nim_game_ctrl.sv
// Directed bench for nim_game_ctrl; a second 9-pile instance lets player 0 take a round.
module tb_nim_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_enter, key_help, key_back, key_up, key_space;
  logic [3:0]  pile_sel, new_val;
  logic [39:0] status;
  logic [1:0]  screen;
  logic        player, round_over, match_over, last_winner, move_ok, move_err;
  logic [2:0]  win0, win1, target;

  logic        b_enter, b_help, b_back, b_up, b_space;
  logic [3:0]  b_pile_sel, b_new_val;
  logic [35:0] b_status;
  logic [1:0]  b_screen;
  logic        b_player, b_round_over, b_match_over, b_last_winner, b_move_ok, b_move_err;
  logic [2:0]  b_win0, b_win1, b_target;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nim_game_ctrl #(.ROUND_HOLD(4)) dut (
    .clk(clk), .rst(rst), .key_enter(key_enter), .key_help(key_help), .key_back(key_back),
    .key_up(key_up), .key_space(key_space), .pile_sel(pile_sel), .new_val(new_val),
    .status(status), .screen(screen), .player(player), .win0(win0), .win1(win1),
    .target(target), .round_over(round_over), .match_over(match_over),
    .last_winner(last_winner), .move_ok(move_ok), .move_err(move_err)
  );

  nim_game_ctrl #(.PILES(9), .ROUND_HOLD(4)) dut9 (
    .clk(clk), .rst(rst), .key_enter(b_enter), .key_help(b_help), .key_back(b_back),
    .key_up(b_up), .key_space(b_space), .pile_sel(b_pile_sel), .new_val(b_new_val),
    .status(b_status), .screen(b_screen), .player(b_player), .win0(b_win0), .win1(b_win1),
    .target(b_target), .round_over(b_round_over), .match_over(b_match_over),
    .last_winner(b_last_winner), .move_ok(b_move_ok), .move_err(b_move_err)
  );

  // One clock: keys set beforehand are sampled on this edge, then all pulses drop.
  task automatic step();
    @(posedge clk);
    #1;
    key_enter = 0; key_help = 0; key_back = 0; key_up = 0; key_space = 0;
    b_enter = 0; b_help = 0; b_back = 0; b_up = 0; b_space = 0;
  endtask

  task automatic play_main(input int n);
    for (int i = 0; i < n; i++) begin
      pile_sel = 4'(i); new_val = 4'h0; key_space = 1; step();
    end
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    n_checks++; if (screen !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_screen got %h want 0", screen); end
    n_checks++; if (status !== 40'h1111111111) begin n_fail++; $display("[TB] FAIL reset_status got %h want 1111111111", status); end
    n_checks++; if (target !== 3'd1) begin n_fail++; $display("[TB] FAIL reset_target got %0d want 1", target); end
    n_checks++; if (player !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_player got %b want 0", player); end
    n_checks++; if (win0 !== 3'd0 || win1 !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_wins got %0d/%0d want 0/0", win0, win1); end
    n_checks++; if ({round_over, match_over, move_ok, move_err, last_winner} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags got %b want 00000", {round_over, match_over, move_ok, move_err, last_winner}); end
  endtask

  task automatic test_setup();
    key_help = 1; step();
    n_checks++; if (screen !== 2'b01) begin n_fail++; $display("[TB] FAIL help_screen got %h want 1", screen); end
    key_back = 1; step();
    n_checks++; if (screen !== 2'b00) begin n_fail++; $display("[TB] FAIL help_back got %h want 0", screen); end
    key_enter = 1; step();
    n_checks++; if (screen !== 2'b10) begin n_fail++; $display("[TB] FAIL setup_screen got %h want 2", screen); end
    for (int i = 0; i < 6; i++) begin key_up = 1; step(); end
    n_checks++; if (target !== 3'd7) begin n_fail++; $display("[TB] FAIL target_max got %0d want 7", target); end
    key_up = 1; step();
    n_checks++; if (target !== 3'd1) begin n_fail++; $display("[TB] FAIL target_wrap got %0d want 1", target); end
    key_help = 1; step();
    n_checks++; if (screen !== 2'b10) begin n_fail++; $display("[TB] FAIL setup_help_ignored got %h want 2", screen); end
  endtask

  task automatic test_move();
    key_enter = 1; step();
    n_checks++; if (screen !== 2'b11 || player !== 1'b0) begin n_fail++; $display("[TB] FAIL play_entry got screen %h player %b want 3/0", screen, player); end
    pile_sel = 4'd3; new_val = 4'd0; key_space = 1; step();
    n_checks++; if (status !== 40'h1111110111) begin n_fail++; $display("[TB] FAIL move_status got %h want 1111110111", status); end
    n_checks++; if (player !== 1'b1 || move_ok !== 1'b1 || move_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL move_ok got player %b ok %b err %b want 1/1/0", player, move_ok, move_err); end
    step();
    n_checks++; if (move_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL move_ok_pulse got %b want 0", move_ok); end
    key_space = 1; step();
    n_checks++; if (move_err !== 1'b1 || move_ok !== 1'b0 || status !== 40'h1111110111 || player !== 1'b1) begin
      n_fail++; $display("[TB] FAIL zero_pile_reject got err %b ok %b status %h player %b", move_err, move_ok, status, player); end
    pile_sel = 4'd12; key_space = 1; step();
    n_checks++; if (move_err !== 1'b1 || status !== 40'h1111110111) begin n_fail++; $display("[TB] FAIL range_reject got err %b status %h", move_err, status); end
    pile_sel = 4'd0; new_val = 4'd1; key_space = 1; step();
    n_checks++; if (move_err !== 1'b1 || status !== 40'h1111110111) begin n_fail++; $display("[TB] FAIL equal_reject got err %b status %h", move_err, status); end
  endtask

  task automatic test_round();
    key_back = 1; step();
    key_enter = 1; step();
    key_up = 1; step();
    key_enter = 1; step();
    n_checks++; if (target !== 3'd2 || status !== 40'h1111111111 || player !== 1'b0) begin
      n_fail++; $display("[TB] FAIL round_start got target %0d status %h player %b", target, status, player); end
    play_main(10);
    n_checks++; if (win1 !== 3'd1 || win0 !== 3'd0 || round_over !== 1'b1 || match_over !== 1'b0) begin
      n_fail++; $display("[TB] FAIL round_win got wins %0d/%0d ro %b mo %b want 0/1/1/0", win0, win1, round_over, match_over); end
    n_checks++; if (last_winner !== 1'b1 || player !== 1'b0 || status !== 40'h0) begin
      n_fail++; $display("[TB] FAIL round_win_state got lw %b player %b status %h", last_winner, player, status); end
    pile_sel = 4'd0; new_val = 4'd0; key_space = 1; step();
    n_checks++; if (move_err !== 1'b0 || move_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL round_end_move_ignored got ok %b err %b", move_ok, move_err); end
    step(); step();
    n_checks++; if (round_over !== 1'b1) begin n_fail++; $display("[TB] FAIL round_hold_early got %b want 1", round_over); end
    step();
    n_checks++; if (round_over !== 1'b0 || screen !== 2'b11 || status !== 40'h1111111111 || player !== 1'b0 || win1 !== 3'd1) begin
      n_fail++; $display("[TB] FAIL round_restart got ro %b screen %h status %h player %b win1 %0d", round_over, screen, status, player, win1); end
  endtask

  task automatic test_match();
    play_main(10);
    n_checks++; if (match_over !== 1'b1 || round_over !== 1'b0 || win1 !== 3'd2 || last_winner !== 1'b1) begin
      n_fail++; $display("[TB] FAIL match_p1 got mo %b ro %b win1 %0d lw %b", match_over, round_over, win1, last_winner); end
    step();
    n_checks++; if (match_over !== 1'b1 || win1 !== 3'd2 || status !== 40'h0) begin
      n_fail++; $display("[TB] FAIL match_hold got mo %b win1 %0d status %h", match_over, win1, status); end
    key_enter = 1; step();
    n_checks++; if (screen !== 2'b00 || win0 !== 3'd0 || win1 !== 3'd0 || match_over !== 1'b0) begin
      n_fail++; $display("[TB] FAIL match_exit got screen %h wins %0d/%0d mo %b", screen, win0, win1, match_over); end
    b_enter = 1; step();
    b_enter = 1; step();
    for (int i = 0; i < 9; i++) begin
      b_pile_sel = 4'(i); b_new_val = 4'h0; b_space = 1; step();
    end
    n_checks++; if (b_match_over !== 1'b1 || b_last_winner !== 1'b0 || b_win0 !== 3'd1 || b_win1 !== 3'd0 || b_status !== 36'h0) begin
      n_fail++; $display("[TB] FAIL match_p0 got mo %b lw %b wins %0d/%0d status %h", b_match_over, b_last_winner, b_win0, b_win1, b_status); end
    b_enter = 1; step();
    n_checks++; if (b_screen !== 2'b00 || b_win0 !== 3'd0) begin n_fail++; $display("[TB] FAIL match_p0_exit got screen %h win0 %0d", b_screen, b_win0); end
  endtask

  task automatic test_back_priority();
    key_enter = 1; step();
    key_enter = 1; step();
    pile_sel = 4'd2; new_val = 4'd0; key_space = 1; key_back = 1; step();
    n_checks++; if (screen !== 2'b00 || status !== 40'h1111111111 || move_ok !== 1'b0 || player !== 1'b0) begin
      n_fail++; $display("[TB] FAIL back_over_space got screen %h status %h ok %b player %b", screen, status, move_ok, player); end
  endtask

  task automatic test_reset_round_end();
    key_enter = 1; step();
    key_enter = 1; step();
    play_main(10);
    n_checks++; if (round_over !== 1'b1 || win1 !== 3'd1) begin n_fail++; $display("[TB] FAIL pre_reset_round got ro %b win1 %0d", round_over, win1); end
    rst = 1; step(); rst = 0;
    n_checks++; if (round_over !== 1'b0 || screen !== 2'b00 || status !== 40'h1111111111 || target !== 3'd1) begin
      n_fail++; $display("[TB] FAIL reset_round_end got ro %b screen %h status %h target %0d", round_over, screen, status, target); end
    n_checks++; if (win1 !== 3'd0 || last_winner !== 1'b0 || player !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_round_end_regs got win1 %0d lw %b player %b", win1, last_winner, player); end
  endtask

  initial begin
    rst = 1;
    key_enter = 0; key_help = 0; key_back = 0; key_up = 0; key_space = 0;
    pile_sel = 0; new_val = 0;
    b_enter = 0; b_help = 0; b_back = 0; b_up = 0; b_space = 0;
    b_pile_sel = 0; b_new_val = 0;
    test_reset();
    test_setup();
    test_move();
    test_round();
    test_match();
    test_back_priority();
    test_reset_round_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
